// File: rtl/serial_receiver.sv
// Serial receiver for 8N1 frames, LSB first, oversampled at 4 clocks per bit.
//
// Ports:
//   clk_x4   in   oversampling clock (4x bit rate), rising edge
//   rst_x    in   asynchronous active-low reset
//   i_rx     in   serial line, idle high, asynchronous to clk_x4
//   o_data   out  last good byte, held until the next good frame
//   o_valid  out  one-cycle pulse when o_data updates
//   o_busy   out  high while a frame is in progress
//   o_error  out  one-cycle pulse when the stop bit is sampled low
//
// The start-detect edge t0 is the edge that sees the synchronised line low in
// StIdle. The phase counter is 0 at t0 and advances every non-idle cycle, so
// phase==1 lands on t0+2+4k, roughly the middle of each bit cell.
module serial_receiver (
  input  logic       clk_x4,
  input  logic       rst_x,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_error
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e     state_q, state_d;
  logic       rx_m_q;
  logic       rx_s_q;  // second synchroniser flop; the only line value used
  logic [1:0] phase_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       sample;

  assign sample = (phase_q == 2'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rx_s_q) state_d = StStart;
      StStart: if (sample) state_d = rx_s_q ? StIdle : StData;
      StData:  if (sample && (bit_cnt_q == 3'd7)) state_d = StStop;
      StStop:  if (sample) state_d = rx_s_q ? StIdle : StBreak;
      // A low line after a framing error is not a new start; wait for idle.
      StBreak: if (rx_s_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_x4 or negedge rst_x) begin
    if (!rst_x) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      o_data    <= 8'h00;
      o_valid   <= 1'b0;
      o_error   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      rx_m_q  <= i_rx;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      o_valid <= 1'b0;
      o_error <= 1'b0;
      // Covers both the leaving edge and the return edge, so busy drops one
      // cycle after the FSM is back in StIdle.
      o_busy  <= (state_d != StIdle) || (state_q != StIdle);

      // Held at 0 in idle, which also makes it 0 right after t0.
      if (state_q == StIdle) phase_q <= 2'd0;
      else                   phase_q <= phase_q + 2'd1;

      unique case (state_q)
        StStart: begin
          if (sample && !rx_s_q) bit_cnt_q <= 3'd0;
        end
        StData: begin
          if (sample) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        StStop: begin
          if (sample) begin
            if (rx_s_q) begin
              o_data  <= shift_q;
              o_valid <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver. Stimulus pushes the expected pulse
// (kind, data, cycle) when a frame starts; a negedge monitor pops and compares
// whenever o_valid or o_error is presented.
module tb_serial_receiver;

  logic       clk_x4 = 1'b0;
  logic       rst_x  = 1'b0;
  logic       i_rx   = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_error;

  serial_receiver dut (
    .clk_x4 (clk_x4),
    .rst_x  (rst_x),
    .i_rx   (i_rx),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_busy (o_busy),
    .o_error(o_error)
  );

  always #5 clk_x4 = ~clk_x4;

  int cyc = 0;
  always @(posedge clk_x4) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;   // expected cycle of the pulse, -1 if not pinned
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk_x4) begin
    if (rst_x && (o_valid || o_error)) begin
      check("valid_error_exclusive", 32'(o_valid & o_error), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({o_valid, o_error}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_error", 32'(o_error), 32'(mon_e.is_err));
        check("pulse_kind_valid", 32'(o_valid), 32'(!mon_e.is_err));
        check("o_data", 32'(o_data), 32'(mon_e.data));
        if (mon_e.cyc >= 0) check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_x4);
    #1;
  endtask

  // Drive one 40-cycle frame starting just after the current edge. The pulse
  // lands 41 edges later: 2 synchroniser flops + detect, then t0+38.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic [7:0] hold);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (stop) sb.push_back('{1'b0, d, cyc + 41});
    else      sb.push_back('{1'b1, hold, cyc + 41});
    for (int i = 0; i < 10; i++) begin
      i_rx = bits[i];
      tick(4);
    end
  endtask

  initial begin
    logic [9:0] abort_bits;

    // Reset state.
    tick(3);
    check("reset_o_data", 32'(o_data), 32'h00);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_error", 32'(o_error), 32'd0);
    check("reset_o_busy", 32'(o_busy), 32'd0);
    rst_x = 1'b1;
    tick(5);
    check("idle_o_busy", 32'(o_busy), 32'd0);

    // Release reset with the line already low: error then break.
    rst_x = 1'b0;
    i_rx  = 1'b0;
    tick(2);
    sb.push_back('{1'b1, 8'h00, -1});
    rst_x = 1'b1;
    tick(60);
    check("low_release_busy_in_break", 32'(o_busy), 32'd1);
    i_rx = 1'b1;
    tick(3);
    check("low_release_busy_before_idle", 32'(o_busy), 32'd1);
    tick(1);
    check("low_release_busy_cleared", 32'(o_busy), 32'd0);
    tick(5);

    // Single clean frame.
    send_frame(8'hA5, 1'b1, 8'h00);
    tick(10);
    check("a5_o_data", 32'(o_data), 32'hA5);

    // Back-to-back at a 40-cycle period.
    send_frame(8'h00, 1'b1, 8'h00);
    send_frame(8'hFF, 1'b1, 8'h00);
    send_frame(8'h55, 1'b1, 8'h00);
    tick(10);

    // Framing error, line held low, then released.
    send_frame(8'h3C, 1'b0, 8'h55);
    tick(20);
    check("break_busy", 32'(o_busy), 32'd1);
    i_rx = 1'b1;
    tick(3);
    check("break_busy_before_idle", 32'(o_busy), 32'd1);
    tick(1);
    check("break_busy_cleared", 32'(o_busy), 32'd0);
    check("error_keeps_o_data", 32'(o_data), 32'h55);

    // Two-cycle glitch on an idle line.
    tick(10);
    i_rx = 1'b0;
    tick(2);
    i_rx = 1'b1;
    tick(2);
    check("glitch_busy", 32'(o_busy), 32'd1);
    tick(2);
    check("glitch_busy_cleared", 32'(o_busy), 32'd0);
    tick(20);
    check("glitch_o_data", 32'(o_data), 32'h55);

    // Reset during bit 4 of 8'hC3, then a clean 8'h81.
    abort_bits = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      i_rx = abort_bits[i];
      tick(4);
    end
    i_rx = abort_bits[5];
    tick(2);
    rst_x = 1'b0;
    i_rx  = 1'b1;
    tick(3);
    check("abort_o_data", 32'(o_data), 32'h00);
    check("abort_o_busy", 32'(o_busy), 32'd0);
    rst_x = 1'b1;
    tick(5);
    send_frame(8'h81, 1'b1, 8'h00);
    tick(10);
    check("after_abort_o_data", 32'(o_data), 32'h81);

    // Bounded drain of any outstanding expectations.
    for (int g = 0; g < 100 && sb.size() != 0; g++) tick(1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have no parameters; the frame format is fixed: 8N1, LSB first, 4 clk_x4 cycles per bit.
REQ-002 SHALL have port: clk_x4  input  1  oversampling clock (4x bit rate), rising edge.
REQ-003 SHALL have port: rst_x  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_rx  input  1  serial line, idle high, asynchronous to clk_x4.
REQ-005 SHALL have port: o_data  output  8  last received byte, held until the next good frame.
REQ-006 SHALL have port: o_valid  output  1  one-cycle pulse when o_data is updated.
REQ-007 SHALL have port: o_busy  output  1  high while a frame is being received (state != IDLE).
REQ-008 SHALL have port: o_error  output  1  one-cycle pulse on framing error (stop bit sampled low).

Function
REQ-009 SHALL pass i_rx through a 2-flop synchronizer; r_rx_s (second flop) is the only line value used by logic.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and BREAK.
REQ-011 SHALL keep a 2-bit phase counter: cleared to 0 on the start-detect edge, then +1 (mod 4) every cycle outside IDLE, and held at 0 in IDLE.
REQ-012 IDLE: the edge at which r_rx_s==0 is the start-detect edge t0 -> START; otherwise stay in IDLE.
REQ-013 SHALL sample the line only on edges where phase==1, i.e. at t0+2+4k for k=0..9.
REQ-014 START sample (k=0): if 0 -> DATA, bit counter=0; if 1 (glitch) -> IDLE, with no o_valid and no o_error.
REQ-015 DATA samples (k=1..8): shift the sampled bit into the MSB of the shift register (shift right); after the 8th bit -> STOP.
REQ-016 STOP sample (k=9, edge t0+38) with value 1: o_data <= shift register, o_valid=1 for exactly the next cycle, -> IDLE.
REQ-017 STOP sample with value 0: o_error=1 for exactly one cycle, o_data unchanged, no o_valid, -> BREAK.
REQ-018 BREAK: stay until r_rx_s==1, then -> IDLE; a low line SHALL NOT be taken as a new start until it has returned high.
REQ-019 SHALL accept back-to-back frames with a 4-cycle stop bit (40-cycle frame period) without losing a byte: IDLE is re-entered at t0+39, before the next start-detect at t0+40.
REQ-020 i_rx activity outside the sample edges SHALL NOT affect state or data.
REQ-021 o_valid and o_error SHALL never be high in the same cycle.
REQ-022 o_busy SHALL be registered: high from the cycle after t0 until the cycle after the return to IDLE.
REQ-023 Latency: o_valid is high in the cycle after edge t0+38.
REQ-024 In loopback from the 4x serial transmitter, o_valid SHALL rise 41 cycles after the transmitter's i_valid sample edge.

Reset
REQ-025 On rst_x low (asynchronous): state=IDLE, phase=0, bit counter=0, shift register=8'h00, o_data=8'h00, o_valid=0, o_error=0, o_busy=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no o_valid or o_error pulse; the receiver SHALL resynchronise on the next falling edge after rst_x is released.
REQ-027 Reset release with i_rx already low SHALL produce a start-detect once r_rx_s goes low; a low stop bit then yields o_error followed by BREAK.

Verification
REQ-028 Loopback with the transmitter, send 8'hA5 -> exactly one o_valid pulse, o_data=8'hA5, o_error never asserted.
REQ-029 Back-to-back 8'h00, 8'hFF, 8'h55 at a 40-cycle period -> three o_valid pulses 40 cycles apart with data 00, FF, 55.
REQ-030 Frame 8'h3C with the stop bit forced low, then line held low 20 cycles, then high -> o_error pulse, no o_valid, o_busy high until 1 cycle after r_rx_s returns high; o_data keeps its previous value.
REQ-031 2-cycle low glitch on an idle line -> START sample reads 1, return to IDLE, no o_valid or o_error.
REQ-032 rst_x pulsed low during bit 4 of 8'hC3, then a clean 8'h81 -> no output for the aborted frame, o_data=8'h00 after reset, then o_valid with 8'h81.
